// File: rtl/seg_scan_display_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : seg_pkg                                                    |
// | Description : Shared constants and the nibble-to-glyph function for the  |
// |               multiplexed 7-segment scan driver. All segment patterns    |
// |               are active-low, ordered a..g with bit 6 = a, bit 0 = g.    |
// | Contents    : SEG_BLANK, GLYPH_0..GLYPH_F, DP_ON/DP_OFF,                  |
// |               blink_phase_e, glyph(nibble, hex_mode)                     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package seg_pkg;

   // All segments dark.
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   // Decimal glyphs, active-low a..g.
   localparam logic [6:0] GLYPH_0 = 7'b0000001;
   localparam logic [6:0] GLYPH_1 = 7'b1001111;
   localparam logic [6:0] GLYPH_2 = 7'b0010010;
   localparam logic [6:0] GLYPH_3 = 7'b0000110;
   localparam logic [6:0] GLYPH_4 = 7'b1001100;
   localparam logic [6:0] GLYPH_5 = 7'b0100100;
   localparam logic [6:0] GLYPH_6 = 7'b0100000;
   localparam logic [6:0] GLYPH_7 = 7'b0001111;
   localparam logic [6:0] GLYPH_8 = 7'b0000000;
   localparam logic [6:0] GLYPH_9 = 7'b0000100;

   // Hex glyphs A b C d E F, active-low a..g.
   localparam logic [6:0] GLYPH_A = 7'b0001000;
   localparam logic [6:0] GLYPH_B = 7'b1100000;
   localparam logic [6:0] GLYPH_C = 7'b0110001;
   localparam logic [6:0] GLYPH_D = 7'b1000010;
   localparam logic [6:0] GLYPH_E = 7'b0110000;
   localparam logic [6:0] GLYPH_F = 7'b0111000;

   // Decimal point drive levels (active-low pin).
   localparam logic DP_ON  = 1'b0;
   localparam logic DP_OFF = 1'b1;

   // Marker blink phase.
   typedef enum logic {
      BLINK_VISIBLE = 1'b0,
      BLINK_HIDDEN  = 1'b1
   } blink_phase_e;

   // Map a nibble to its glyph; codes 10..15 are blank unless hex_mode.
   function automatic logic [6:0] glyph(input logic [3:0] nibble,
                                        input logic       hex_mode);
      logic [6:0] g;
      g = SEG_BLANK;
      case (nibble)
         4'h0:    g = GLYPH_0;
         4'h1:    g = GLYPH_1;
         4'h2:    g = GLYPH_2;
         4'h3:    g = GLYPH_3;
         4'h4:    g = GLYPH_4;
         4'h5:    g = GLYPH_5;
         4'h6:    g = GLYPH_6;
         4'h7:    g = GLYPH_7;
         4'h8:    g = GLYPH_8;
         4'h9:    g = GLYPH_9;
         4'hA:    g = hex_mode ? GLYPH_A : SEG_BLANK;
         4'hB:    g = hex_mode ? GLYPH_B : SEG_BLANK;
         4'hC:    g = hex_mode ? GLYPH_C : SEG_BLANK;
         4'hD:    g = hex_mode ? GLYPH_D : SEG_BLANK;
         4'hE:    g = hex_mode ? GLYPH_E : SEG_BLANK;
         4'hF:    g = hex_mode ? GLYPH_F : SEG_BLANK;
         default: g = SEG_BLANK;
      endcase
      return g;
   endfunction

endpackage
`default_nettype wire

// File: rtl/seg_scan_display_hex_to_seg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : hex_to_seg                                                 |
// | Description : Combinational nibble-to-7-segment decoder shared by all    |
// |               digits of the scan driver.                                 |
// | Ports       : nibble   in  4  value to display                           |
// |               hex_mode in  1  1 = show A..F for 10..15, 0 = blank        |
// |               seg7     out 7  active-low a..g (bit 6 = a, bit 0 = g)     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module hex_to_seg
   import seg_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       hex_mode,
   output logic [6:0] seg7
);

   always_comb begin
      seg7 = glyph(nibble, hex_mode);
   end

endmodule
`default_nettype wire

// File: rtl/seg_scan_display.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : seg_scan_display                                           |
// | Description : Time-multiplexed driver for DIGITS common-anode 7-segment  |
// |               digits. A prescaler paces the digit sequencer; display     |
// |               data is double-buffered and swapped only at frame wrap so  |
// |               a frame never mixes old and new values. One shared decoder |
// |               sits after the digit mux. A marker digit can be flagged    |
// |               with its DP and optionally blinked every BLINK_FRAMES.     |
// | Ports       : clk        in  1          system clock                    |
// |               rst_n      in  1          async active-low reset          |
// |               data       in  4*DIGITS   nibble i = digit i (0=rightmost)|
// |               load       in  1          capture strobe for data         |
// |               en_mask    in  DIGITS     1 = digit lit                   |
// |               dp_mask    in  DIGITS     1 = DP lit                      |
// |               mark_en    in  1          marker enable                   |
// |               mark_idx   in  clog2(D)   marker digit                    |
// |               an         out DIGITS     anode selects, active-low       |
// |               seg        out 8          {dp, a..g}, active-low          |
// |               frame_done out 1          pulse on the frame-wrap cycle   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module seg_scan_display
   import seg_pkg::*;
#(
   parameter int DIGITS       = 8,
   parameter int SCAN_DIV     = 100000,
   parameter int HEX_MODE     = 1,
   parameter int BLINK_FRAMES = 32
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [4*DIGITS-1:0]        data,
   input  logic                       load,
   input  logic [DIGITS-1:0]          en_mask,
   input  logic [DIGITS-1:0]          dp_mask,
   input  logic                       mark_en,
   input  logic [$clog2(DIGITS)-1:0]  mark_idx,
   output logic [DIGITS-1:0]          an,
   output logic [7:0]                 seg,
   output logic                       frame_done
);

   localparam int IDX_W = $clog2(DIGITS);
   localparam int PRE_W = $clog2(SCAN_DIV);
   localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [PRE_W-1:0]       pre_q,     pre_d;
   logic [IDX_W-1:0]       idx_q,     idx_d;
   logic [DIGITS-1:0][3:0] staging_q, staging_d;
   logic [DIGITS-1:0][3:0] shadow_q,  shadow_d;
   logic                   pending_q, pending_d;
   logic [DIGITS-1:0]      an_q,      an_d;
   logic [7:0]             seg_q,     seg_d;

   logic                   tick;
   logic                   wrap;
   logic                   mark_hit;
   logic                   blink_hidden;
   logic [3:0]             nibble_sel;
   logic [6:0]             glyph_sel;

   // idx_q names the digit that will be driven at the next tick, so the
   // wrap tick is the one that presents the last digit of the frame.
   assign tick = (pre_q == PRE_W'(SCAN_DIV - 1));
   assign wrap = tick && (idx_q == IDX_W'(DIGITS - 1));

   // mark_idx values beyond DIGITS-1 can never equal idx_q, so they
   // naturally disable the marker.
   assign mark_hit   = mark_en && (mark_idx == idx_q);
   assign nibble_sel = shadow_q[idx_q];

   hex_to_seg u_hex_to_seg (
      .nibble   (nibble_sel),
      .hex_mode (HEX_MODE != 0),
      .seg7     (glyph_sel)
   );

   // ---------------------------------------------------------------------
   // Scan timing and double buffer
   // ---------------------------------------------------------------------
   always_comb begin
      pre_d     = tick ? '0 : pre_q + PRE_W'(1);
      idx_d     = idx_q;
      staging_d = load ? data : staging_q;
      shadow_d  = shadow_q;
      pending_d = pending_q;

      if (tick) begin
         idx_d = wrap ? '0 : idx_q + IDX_W'(1);
      end

      // The shadow only changes at the wrap edge, after the last digit of
      // the outgoing frame has been latched from the old contents. A load
      // on the wrap cycle itself bypasses staging so it is not lost.
      if (wrap) begin
         if (load) begin
            shadow_d = data;
         end else if (pending_q) begin
            shadow_d = staging_q;
         end
         pending_d = 1'b0;
      end else if (load) begin
         pending_d = 1'b1;
      end
   end

   // ---------------------------------------------------------------------
   // Registered pin drive; an and seg always move together on a tick.
   // ---------------------------------------------------------------------
   always_comb begin
      an_d  = an_q;
      seg_d = seg_q;
      if (tick) begin
         // A masked digit still consumes its slot, keeping the refresh
         // rate independent of the mask.
         an_d       = en_mask[idx_q] ? ~(DIGITS'(1) << idx_q) : '1;
         seg_d[6:0] = (mark_hit && blink_hidden) ? SEG_BLANK : glyph_sel;
         seg_d[7]   = (dp_mask[idx_q] || mark_hit) ? DP_ON : DP_OFF;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_q     <= '0;
         idx_q     <= '0;
         staging_q <= '0;
         shadow_q  <= '0;
         pending_q <= 1'b0;
         an_q      <= '1;
         seg_q     <= 8'hFF;
      end else begin
         pre_q     <= pre_d;
         idx_q     <= idx_d;
         staging_q <= staging_d;
         shadow_q  <= shadow_d;
         pending_q <= pending_d;
         an_q      <= an_d;
         seg_q     <= seg_d;
      end
   end

   // ---------------------------------------------------------------------
   // Marker blink: phase toggles every BLINK_FRAMES frame wraps.
   // ---------------------------------------------------------------------
   generate
      if (BLINK_FRAMES > 0) begin : g_blink
         logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
         blink_phase_e     blink_phase_q, blink_phase_d;

         always_comb begin
            blink_cnt_d   = blink_cnt_q;
            blink_phase_d = blink_phase_q;
            if (wrap) begin
               if (blink_cnt_q == BLK_W'(BLINK_FRAMES - 1)) begin
                  blink_cnt_d   = '0;
                  blink_phase_d = (blink_phase_q == BLINK_VISIBLE) ?
                                  BLINK_HIDDEN : BLINK_VISIBLE;
               end else begin
                  blink_cnt_d = blink_cnt_q + BLK_W'(1);
               end
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               blink_cnt_q   <= '0;
               blink_phase_q <= BLINK_VISIBLE;
            end else begin
               blink_cnt_q   <= blink_cnt_d;
               blink_phase_q <= blink_phase_d;
            end
         end

         assign blink_hidden = (blink_phase_q == BLINK_HIDDEN);
      end else begin : g_no_blink
         // Marker is flagged by its DP only and never blanks.
         assign blink_hidden = 1'b0;
      end
   endgenerate

   assign an         = an_q;
   assign seg        = seg_q;
   assign frame_done = wrap;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_display.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_seg_scan_display                                        |
// | Description : Self-checking bench for seg_scan_display with DIGITS=4,    |
// |               SCAN_DIV=4, BLINK_FRAMES=2. Two instances share stimulus:  |
// |               one with hex glyphs, one with hex codes blanked. A model   |
// |               derives slot, digit and frame numbers from the cycle count |
// |               since reset and checks every cycle; directed sections pin  |
// |               literal values.                                            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_seg_scan_display;

   localparam int DIGITS    = 4;
   localparam int SCAN_DIV  = 4;
   localparam int BF        = 2;
   localparam int FRAME_CYC = DIGITS * SCAN_DIV;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] data;
   logic        load;
   logic [3:0]  en_mask;
   logic [3:0]  dp_mask;
   logic        mark_en;
   logic [1:0]  mark_idx;

   logic [3:0]  an_h, an_d;
   logic [7:0]  seg_h, seg_d;
   logic        fd_h, fd_d;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   seg_scan_display #(
      .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .HEX_MODE(1), .BLINK_FRAMES(BF)
   ) dut_h (
      .clk(clk), .rst_n(rst_n), .data(data), .load(load),
      .en_mask(en_mask), .dp_mask(dp_mask), .mark_en(mark_en),
      .mark_idx(mark_idx), .an(an_h), .seg(seg_h), .frame_done(fd_h)
   );

   seg_scan_display #(
      .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .HEX_MODE(0), .BLINK_FRAMES(BF)
   ) dut_d (
      .clk(clk), .rst_n(rst_n), .data(data), .load(load),
      .en_mask(en_mask), .dp_mask(dp_mask), .mark_en(mark_en),
      .mark_idx(mark_idx), .an(an_d), .seg(seg_d), .frame_done(fd_d)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, want %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [6:0] ref_glyph(input logic [3:0] v, input bit hex);
      logic [6:0] g;
      case (v)
         4'h0: g = 7'b0000001;  4'h1: g = 7'b1001111;
         4'h2: g = 7'b0010010;  4'h3: g = 7'b0000110;
         4'h4: g = 7'b1001100;  4'h5: g = 7'b0100100;
         4'h6: g = 7'b0100000;  4'h7: g = 7'b0001111;
         4'h8: g = 7'b0000000;  4'h9: g = 7'b0000100;
         4'hA: g = 7'b0001000;  4'hB: g = 7'b1100000;
         4'hC: g = 7'b0110001;  4'hD: g = 7'b1000010;
         4'hE: g = 7'b0110000;  default: g = 7'b0111000;
      endcase
      if (!hex && v > 4'd9) g = 7'b1111111;
      return g;
   endfunction

   // Outputs latched at the n-th clock edge after reset (n a multiple of
   // SCAN_DIV): slot s = n/SCAN_DIV-1 shows digit s%DIGITS of frame s/DIGITS.
   function automatic logic [7:0] ref_seg(input int n, input logic [15:0] disp,
                                          input bit hex);
      int s, k, f;
      logic [15:0] sh;
      logic [3:0] nib;
      bit hit, hidden;
      s = n / SCAN_DIV - 1;
      k = s % DIGITS;
      f = s / DIGITS;
      sh = disp >> (4 * k);
      nib = sh[3:0];
      hit = mark_en && (int'(mark_idx) == k);
      hidden = ((f / BF) % 2) == 1;
      return {(dp_mask[k] || hit) ? 1'b0 : 1'b1,
              (hit && hidden) ? 7'b1111111 : ref_glyph(nib, hex)};
   endfunction

   function automatic logic [3:0] ref_an(input int n);
      int k;
      k = (n / SCAN_DIV - 1) % DIGITS;
      return en_mask[k] ? ~(4'b0001 << k) : 4'b1111;
   endfunction

   int          m_n;
   logic [15:0] m_disp, m_latest;
   bit          m_have;
   logic [3:0]  exp_an;
   logic [7:0]  exp_seg_h, exp_seg_d;
   logic        exp_fd;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_n       <= 0;
         m_disp    <= '0;
         m_latest  <= '0;
         m_have    <= 1'b0;
         exp_an    <= 4'hF;
         exp_seg_h <= 8'hFF;
         exp_seg_d <= 8'hFF;
         exp_fd    <= 1'b0;
      end else begin
         m_n <= m_n + 1;
         if ((m_n + 1) % SCAN_DIV == 0) begin
            exp_an    <= ref_an(m_n + 1);
            exp_seg_h <= ref_seg(m_n + 1, m_disp, 1'b1);
            exp_seg_d <= ref_seg(m_n + 1, m_disp, 1'b0);
         end
         exp_fd <= ((m_n + 2) % FRAME_CYC) == 0;
         // Newest load since the previous frame boundary becomes the
         // next frame's data; a load on the boundary edge itself counts.
         if ((m_n + 1) % FRAME_CYC == 0) begin
            if (load)        m_disp <= data;
            else if (m_have) m_disp <= m_latest;
            m_have <= 1'b0;
         end else if (load) begin
            m_have <= 1'b1;
         end
         if (load) m_latest <= data;
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         chk("an_h",  32'(an_h),  32'(exp_an));
         chk("an_d",  32'(an_d),  32'(exp_an));
         chk("seg_h", 32'(seg_h), 32'(exp_seg_h));
         chk("seg_d", 32'(seg_d), 32'(exp_seg_d));
         chk("fd_h",  32'(fd_h),  32'(exp_fd));
         chk("fd_d",  32'(fd_d),  32'(exp_fd));
      end
   end

   // ---------------- directed helpers ----------------
   task automatic wait_fd();
      int t;
      t = 0;
      @(negedge clk);
      while (fd_h !== 1'b1 && t < 40) begin
         @(negedge clk);
         t++;
      end
      chk("fd_wait", 32'(fd_h), 32'd1);
   endtask

   // Returns just after the wrap edge, i.e. as digit DIGITS-1 is latched.
   task automatic sync_frame();
      wait_fd();
      @(posedge clk);
   endtask

   task automatic next_slot();
      repeat (SCAN_DIV) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic pulse_load(input logic [15:0] v);
      @(negedge clk);
      data = v;
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
   endtask

   logic [3:0] scan_an  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
   logic [6:0] scan_seg [4] = '{7'b1001111, 7'b0000110, 7'b0001000, 7'b0000100};

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int cnt;
      bit hidden [8];
      int nhid;
      logic [6:0] g;

      data = '0; load = 1'b0; en_mask = 4'hF; dp_mask = 4'h0;
      mark_en = 1'b0; mark_idx = 2'd0;

      // Reset and first tick
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("rst_an", 32'(an_h), 32'h0F);
         chk("rst_seg", 32'(seg_h), 32'hFF);
      end
      @(negedge clk);
      chk("tick1_an", 32'(an_h), 32'b1110);
      chk("tick1_seg", 32'(seg_h), 32'b10000001);

      // Scan order with 9A31
      pulse_load(16'h9A31);
      sync_frame();
      for (int k = 0; k < 4; k++) begin
         next_slot();
         chk("scan_an", 32'(an_h), 32'(scan_an[k]));
         chk("scan_seg", 32'(seg_h[6:0]), 32'(scan_seg[k]));
      end
      cnt = 0;
      repeat (32) begin
         @(negedge clk);
         if (fd_h) cnt++;
      end
      chk("fd_count", 32'(cnt), 32'd2);

      // Tearing: two loads mid-frame, last wins at the next frame only
      sync_frame();
      repeat (5) @(negedge clk);
      pulse_load(16'h1111);
      pulse_load(16'h2222);
      sync_frame();
      @(negedge clk);
      chk("tear_old", 32'(seg_h[6:0]), 32'b0000100);
      for (int k = 0; k < 4; k++) begin
         next_slot();
         chk("tear_new", 32'(seg_h[6:0]), 32'b0010010);
      end

      // Load coincident with frame_done
      wait_fd();
      data = 16'h4444;
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      for (int k = 0; k < 4; k++) begin
         repeat (SCAN_DIV) @(posedge clk);
         @(negedge clk);
         chk("coinc", 32'(seg_h[6:0]), 32'b1001100);
      end

      // Enable / DP masks
      en_mask = 4'b0101;
      dp_mask = 4'b0001;
      sync_frame();
      next_slot();
      chk("mask0_an", 32'(an_h), 32'b1110);
      chk("mask0_dp", 32'(seg_h[7]), 32'd0);
      next_slot();
      chk("mask1_an", 32'(an_h), 32'b1111);
      next_slot();
      chk("mask2_an", 32'(an_h), 32'b1011);
      chk("mask2_dp", 32'(seg_h[7]), 32'd1);
      next_slot();
      chk("mask3_an", 32'(an_h), 32'b1111);

      // Marker blink on digit 2 showing 7
      en_mask = 4'hF;
      dp_mask = 4'h0;
      mark_en = 1'b1;
      mark_idx = 2'd2;
      pulse_load(16'h0700);
      nhid = 0;
      for (int fr = 0; fr < 8; fr++) begin
         sync_frame();
         repeat (3) next_slot();
         g = seg_h[6:0];
         chk("blink_glyph", 32'(g == 7'b0001111 || g == 7'b1111111), 32'd1);
         chk("blink_dp", 32'(seg_h[7]), 32'd0);
         hidden[fr] = (g == 7'b1111111);
         if (hidden[fr]) nhid++;
      end
      for (int i = 0; i < 6; i++) chk("blink_period", 32'(hidden[i+2]), 32'(!hidden[i]));
      chk("blink_count", 32'(nhid), 32'd4);

      // Marker on a disabled digit stays dark
      en_mask = 4'b0111;
      mark_idx = 2'd3;
      sync_frame();
      repeat (4) next_slot();
      chk("mark_dark_an", 32'(an_h), 32'b1111);
      chk("mark_dark_dp", 32'(seg_h[7]), 32'd0);

      // Hex code C: glyph with hex, blank without
      mark_en = 1'b0;
      en_mask = 4'hF;
      pulse_load(16'h00C0);
      sync_frame();
      repeat (2) next_slot();
      chk("hex0_C", 32'(seg_d[6:0]), 32'h7F);
      chk("hex1_C", 32'(seg_h[6:0]), 32'b0110001);

      // Randomized traffic
      repeat (400) begin
         @(posedge clk);
         #2;
         load = ($urandom_range(0, 5) == 0);
         data = 16'($urandom);
         if ($urandom_range(0, 15) == 0) begin
            en_mask  = 4'($urandom_range(0, 15));
            dp_mask  = 4'($urandom_range(0, 15));
            mark_en  = 1'($urandom_range(0, 1));
            mark_idx = 2'($urandom_range(0, 3));
         end
      end

      // Asynchronous reset mid-cycle
      @(posedge clk);
      #2;
      load = 1'b0;
      en_mask = 4'hF;
      dp_mask = 4'hF;
      repeat (10) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_an", 32'(an_h), 32'h0F);
      chk("arst_seg_h", 32'(seg_h), 32'hFF);
      chk("arst_seg_d", 32'(seg_d), 32'hFF);
      chk("arst_fd", 32'(fd_h), 32'd0);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;

      repeat (200) begin
         @(posedge clk);
         #2;
         load = ($urandom_range(0, 3) == 0);
         data = 16'($urandom);
         if ($urandom_range(0, 7) == 0) begin
            en_mask  = 4'($urandom_range(0, 15));
            dp_mask  = 4'($urandom_range(0, 15));
            mark_en  = 1'($urandom_range(0, 1));
            mark_idx = 2'($urandom_range(0, 3));
         end
      end

      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
